// File: rtl/gpu_pkg.sv
// Shared geometry, widths and types for the back-buffer drawing engine.
// Pulled in by the rasteriser FSM and its Bresenham stepper.
package gpu_pkg;

    localparam int FB_W    = 320;
    localparam int FB_H    = 240;
    localparam int COORD_W = 10;
    localparam int PIX_W   = 4;
    localparam int ERR_W   = 12;

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(FB_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(FB_H - 1);

    typedef enum logic [2:0] {
        CLEAR,
        WAIT_CMD,
        SETUP,
        DRAW,
        DONE
    } raster_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [PIX_W-1:0]   color;
        logic               last;
    } line_cmd_t;

    function automatic logic in_frame(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return (x < COORD_W'(FB_W)) && (y < COORD_W'(FB_H));
    endfunction

endpackage

// File: rtl/line_stepper.sv
// Bresenham datapath: i_load captures endpoints and derives dx/dy/err/sx/sy,
// each i_step advances one pixel; o_at_end flags the current point is the end point.
module line_stepper
    import gpu_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_x1,
    input  logic [COORD_W-1:0] i_y1,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_at_end
);

    logic [COORD_W-1:0]      r_x, r_y;
    logic signed [ERR_W-1:0] r_err, r_dx, r_dy;
    logic                    r_sx_neg, r_sy_neg;

    logic [COORD_W-1:0]      w_adx, w_ady;
    logic signed [ERR_W-1:0] w_dx, w_dy, w_ex, w_ey;
    logic signed [ERR_W:0]   w_e2;
    logic                    w_mv_x, w_mv_y;

    assign w_adx = (i_x0 > i_x1) ? (i_x0 - i_x1) : (i_x1 - i_x0);
    assign w_ady = (i_y0 > i_y1) ? (i_y0 - i_y1) : (i_y1 - i_y0);
    assign w_dx  = $signed({{(ERR_W-COORD_W){1'b0}}, w_adx});
    assign w_dy  = -$signed({{(ERR_W-COORD_W){1'b0}}, w_ady});

    // Both axis decisions compare against the same pre-update error.
    assign w_e2   = {r_err, 1'b0};
    assign w_mv_x = (w_e2 >= r_dy);
    assign w_mv_y = (w_e2 <= r_dx);
    assign w_ex   = w_mv_x ? r_dy : '0;
    assign w_ey   = w_mv_y ? r_dx : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_err    <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
        end else if (i_load) begin
            r_x      <= i_x0;
            r_y      <= i_y0;
            r_dx     <= w_dx;
            r_dy     <= w_dy;
            r_err    <= w_dx + w_dy;
            r_sx_neg <= !(i_x0 < i_x1);
            r_sy_neg <= !(i_y0 < i_y1);
        end else if (i_step) begin
            r_err <= r_err + w_ex + w_ey;
            if (w_mv_x) r_x <= r_sx_neg ? (r_x - 10'd1) : (r_x + 10'd1);
            if (w_mv_y) r_y <= r_sy_neg ? (r_y - 10'd1) : (r_y + 10'd1);
        end
    end

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_at_end = (r_x == i_x1) && (r_y == i_y1);

endmodule

// File: rtl/line_rasterizer.sv
// Per frame: optional raster clear to BG_COLOR, then Bresenham lines from a valid/ready
// command stream, one pixel per clock; raises gpu_done after the last line until gpu_start.
module line_rasterizer
    import gpu_pkg::*;
#(
    parameter logic [PIX_W-1:0] BG_COLOR = 4'h0,
    parameter bit               CLEAR_EN = 1'b1
) (
    input  logic               gpu_clk_150,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    input  logic [PIX_W-1:0]   cmd_color,
    input  logic               cmd_last,
    input  logic               gpu_start,
    output logic [COORD_W-1:0] gpu_x,
    output logic [COORD_W-1:0] gpu_y,
    output logic [PIX_W-1:0]   gpu_data,
    output logic               gpu_we,
    output logic               gpu_done
);

    localparam raster_state_t FRAME_START = CLEAR_EN ? CLEAR : WAIT_CMD;

    raster_state_t      r_state, w_next;
    line_cmd_t          r_cmd;
    logic [COORD_W-1:0] r_cx, r_cy;
    logic [COORD_W-1:0] w_px, w_py;
    logic               w_at_end, w_hs, w_clear_end, w_load, w_step;

    assign w_hs        = cmd_valid && cmd_ready && (r_state == WAIT_CMD);
    assign w_clear_end = (r_cx == X_MAX) && (r_cy == Y_MAX);
    assign w_load      = (r_state == SETUP);
    assign w_step      = (r_state == DRAW) && !w_at_end;

    always_comb begin
        w_next = r_state;
        case (r_state)
            CLEAR:    if (w_clear_end) w_next = WAIT_CMD;
            WAIT_CMD: if (w_hs) w_next = SETUP;
            SETUP:    w_next = DRAW;
            DRAW:     if (w_at_end) w_next = r_cmd.last ? DONE : WAIT_CMD;
            DONE:     if (gpu_start) w_next = FRAME_START;
            default:  w_next = FRAME_START;
        endcase
    end

    always_ff @(posedge gpu_clk_150 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FRAME_START;
            r_cmd   <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                r_cmd <= '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1,
                           color: cmd_color, last: cmd_last};
            end
            // Counters wrap to (0,0) at the end of the pass, ready for the next frame.
            if (r_state == CLEAR) begin
                if (r_cx == X_MAX) begin
                    r_cx <= '0;
                    r_cy <= (r_cy == Y_MAX) ? '0 : (r_cy + 10'd1);
                end else begin
                    r_cx <= r_cx + 10'd1;
                end
            end
        end
    end

    // Handshake/status outputs track the upcoming state so they stay registered yet current.
    always_ff @(posedge gpu_clk_150 or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready <= 1'b0;
            gpu_done  <= 1'b0;
            gpu_we    <= 1'b0;
            gpu_x     <= '0;
            gpu_y     <= '0;
            gpu_data  <= '0;
        end else begin
            cmd_ready <= (w_next == WAIT_CMD);
            gpu_done  <= (w_next == DONE);
            gpu_we    <= 1'b0;
            if (r_state == CLEAR) begin
                gpu_we   <= 1'b1;
                gpu_x    <= r_cx;
                gpu_y    <= r_cy;
                gpu_data <= BG_COLOR;
            end else if ((r_state == DRAW) && in_frame(w_px, w_py)) begin
                gpu_we   <= 1'b1;
                gpu_x    <= w_px;
                gpu_y    <= w_py;
                gpu_data <= r_cmd.color;
            end
        end
    end

    line_stepper u_stepper (
        .i_clk    (gpu_clk_150),
        .i_rst_n  (reset_n),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_x0     (r_cmd.x0),
        .i_y0     (r_cmd.y0),
        .i_x1     (r_cmd.x1),
        .i_y1     (r_cmd.y1),
        .o_x      (w_px),
        .o_y      (w_py),
        .o_at_end (w_at_end)
    );

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench: two engines clear in parallel; A runs line/clip/reset cases,
// B runs the end-of-frame gpu_done / gpu_start handshake.
module tb_line_rasterizer;

    logic       clk = 1'b0;
    logic       rst_a_n, rst_b_n, vld_a, vld_b, gstart, last;
    logic [9:0] x0, y0, x1, y1;
    logic [3:0] col;

    logic       a_rdy, a_we, a_done, b_rdy, b_we, b_done;
    logic [9:0] a_x, a_y, b_x, b_y;
    logic [3:0] a_d, b_d;

    int n_vec  = 0;
    int n_miss = 0;

    logic       rec_we  [16];
    logic       rec_rdy [16];
    logic [9:0] rec_x   [16];
    logic [9:0] rec_y   [16];
    logic [3:0] rec_d   [16];

    always #5 clk = ~clk;

    line_rasterizer #(.BG_COLOR(4'h3), .CLEAR_EN(1'b1)) u_dut_a (
        .gpu_clk_150(clk), .reset_n(rst_a_n),
        .cmd_valid(vld_a), .cmd_ready(a_rdy),
        .cmd_x0(x0), .cmd_y0(y0), .cmd_x1(x1), .cmd_y1(y1),
        .cmd_color(col), .cmd_last(last), .gpu_start(gstart),
        .gpu_x(a_x), .gpu_y(a_y), .gpu_data(a_d), .gpu_we(a_we), .gpu_done(a_done)
    );

    line_rasterizer #(.BG_COLOR(4'h3), .CLEAR_EN(1'b1)) u_dut_b (
        .gpu_clk_150(clk), .reset_n(rst_b_n),
        .cmd_valid(vld_b), .cmd_ready(b_rdy),
        .cmd_x0(x0), .cmd_y0(y0), .cmd_x1(x1), .cmd_y1(y1),
        .cmd_color(col), .cmd_last(last), .gpu_start(gstart),
        .gpu_x(b_x), .gpu_y(b_y), .gpu_data(b_d), .gpu_we(b_we), .gpu_done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic send(input bit sel, input logic [9:0] ax0, input logic [9:0] ay0,
                        input logic [9:0] ax1, input logic [9:0] ay1,
                        input logic [3:0] c, input logic l);
        int t = 0;
        while (((sel ? b_rdy : a_rdy) !== 1'b1) && (t < 100)) begin
            @(negedge clk);
            t++;
        end
        chk("rdy_wait", 32'(t < 100), 1);
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; col = c; last = l;
        if (sel) vld_b = 1'b1;
        else     vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        vld_b = 1'b0;
    endtask

    task automatic run_a(input logic [9:0] ax0, input logic [9:0] ay0,
                         input logic [9:0] ax1, input logic [9:0] ay1,
                         input logic [3:0] c, input int n);
        send(1'b0, ax0, ay0, ax1, ay1, c, 1'b0);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            rec_we[k] = a_we; rec_rdy[k] = a_rdy;
            rec_x[k] = a_x; rec_y[k] = a_y; rec_d[k] = a_d;
        end
    endtask

    function automatic int count_we(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (rec_we[k]) c++;
        return c;
    endfunction

    initial begin
        int cnt, bad, ex, ey, wcnt;
        logic [9:0] lx, ly;
        int l2x[6] = '{0, 0, 1, 1, 2, 2};
        int l2y[6] = '{0, 1, 2, 3, 4, 5};

        rst_a_n = 1'b0; rst_b_n = 1'b0; vld_a = 1'b0; vld_b = 1'b0; gstart = 1'b0;
        last = 1'b0; x0 = '0; y0 = '0; x1 = '0; y1 = '0; col = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_we",   32'(a_we), 0);
        chk("rst_rdy",  32'(a_rdy), 0);
        chk("rst_x",    32'(a_x), 0);

        // ---- clear pass (both engines) ----
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(negedge clk);
        chk("clr_first_we", 32'(a_we), 1);
        chk("clr_first_xy", 32'({a_x, a_y}), 0);
        cnt = 0; bad = 0; ex = 0; ey = 0; lx = '0; ly = '0;
        for (int i = 0; i < 80000 && a_we === 1'b1; i++) begin
            if (a_x !== 10'(ex) || a_y !== 10'(ey) || a_d !== 4'h3) bad++;
            lx = a_x; ly = a_y; cnt++;
            if (ex == 319) begin ex = 0; ey++; end
            else ex++;
            @(negedge clk);
        end
        chk("clr_count", cnt, 76800);
        chk("clr_order_data", bad, 0);
        chk("clr_last_x", 32'(lx), 319);
        chk("clr_last_y", 32'(ly), 239);
        chk("clr_then_rdy_a", 32'(a_rdy), 1);
        chk("clr_then_rdy_b", 32'(b_rdy), 1);

        // ---- horizontal line (10,5)->(14,5) ----
        run_a(10'd10, 10'd5, 10'd14, 10'd5, 4'hF, 8);
        chk("l1_k1_we", 32'(rec_we[1]), 0);
        for (int k = 2; k <= 6; k++) begin
            chk($sformatf("l1_we%0d", k), 32'(rec_we[k]), 1);
            chk($sformatf("l1_x%0d", k),  32'(rec_x[k]), 32'(8 + k));
            chk($sformatf("l1_y%0d", k),  32'(rec_y[k]), 5);
            chk($sformatf("l1_d%0d", k),  32'(rec_d[k]), 15);
        end
        for (int k = 1; k <= 5; k++) chk($sformatf("l1_rdy%0d", k), 32'(rec_rdy[k]), 0);
        chk("l1_rdy_back", 32'(rec_rdy[7]), 1);
        chk("l1_writes", count_we(8), 5);

        // ---- steep line (0,0)->(2,5) ----
        run_a(10'd0, 10'd0, 10'd2, 10'd5, 4'h8, 9);
        for (int k = 2; k <= 7; k++) begin
            chk($sformatf("l2_we%0d", k), 32'(rec_we[k]), 1);
            chk($sformatf("l2_x%0d", k),  32'(rec_x[k]), 32'(l2x[k-2]));
            chk($sformatf("l2_y%0d", k),  32'(rec_y[k]), 32'(l2y[k-2]));
        end
        chk("l2_writes", count_we(9), 6);

        // ---- clipped line (318,10)->(322,10) ----
        run_a(10'd318, 10'd10, 10'd322, 10'd10, 4'h7, 9);
        chk("l3_writes", count_we(9), 2);
        chk("l3_x318", 32'(rec_x[2]), 318);
        chk("l3_x319", 32'(rec_x[3]), 319);
        chk("l3_clip_we", 32'(rec_we[4]), 0);
        chk("l3_clip_hold", 32'(rec_x[4]), 319);
        chk("l3_rdy_k5", 32'(rec_rdy[5]), 0);
        chk("l3_rdy_k6", 32'(rec_rdy[6]), 1);

        // ---- point (5,5)->(5,5) ----
        run_a(10'd5, 10'd5, 10'd5, 10'd5, 4'hA, 6);
        chk("l4_writes", count_we(6), 1);
        chk("l4_xy", 32'({rec_x[2], rec_y[2]}), 32'({10'd5, 10'd5}));
        chk("l4_d", 32'(rec_d[2]), 10);

        // ---- engine B: final command, done hold, restart ----
        send(1'b1, 10'd1, 10'd1, 10'd2, 10'd1, 4'h9, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("b_px1", 32'({b_we, b_x, b_y}), 32'({1'b1, 10'd1, 10'd1}));
        chk("b_done_early", 32'(b_done), 0);
        @(negedge clk);
        chk("b_px2", 32'({b_we, b_x, b_y}), 32'({1'b1, 10'd2, 10'd1}));
        @(negedge clk);
        chk("b_done_up", 32'(b_done), 1);
        vld_b = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (b_done !== 1'b1 || b_we !== 1'b0 || b_rdy !== 1'b0) bad++;
        end
        chk("b_done_hold", bad, 0);
        vld_b = 1'b0;
        gstart = 1'b1;
        @(negedge clk);
        chk("b_done_drop", 32'(b_done), 0);
        gstart = 1'b0;
        @(negedge clk);
        chk("b_restart", 32'({b_we, b_x, b_y, b_d}), 32'({1'b1, 10'd0, 10'd0, 4'h3}));

        // ---- engine A: reset at pixel 40 of (0,0)->(100,0) ----
        send(1'b0, 10'd0, 10'd0, 10'd100, 10'd0, 4'hC, 1'b0);
        for (int k = 1; k <= 41; k++) @(negedge clk);
        chk("r_px40", 32'({a_we, a_x, a_d}), 32'({1'b1, 10'd39, 4'hC}));
        rst_a_n = 1'b0;
        #1;
        chk("r_we", 32'(a_we), 0);
        chk("r_xy", 32'({a_x, a_y, a_d}), 0);
        chk("r_rdy_done", 32'({a_rdy, a_done}), 0);
        @(negedge clk); @(negedge clk);
        rst_a_n = 1'b1;
        @(negedge clk);
        chk("r_restart", 32'({a_we, a_x, a_y, a_d}), 32'({1'b1, 10'd0, 10'd0, 4'h3}));
        bad = 0; wcnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (a_we === 1'b1) wcnt++;
            if (a_we !== 1'b1 || a_x !== 10'(i) || a_y !== 10'd0 || a_d !== 4'h3) bad++;
            @(negedge clk);
        end
        chk("r_clear_seq", bad, 0);
        chk("r_clear_cnt", wcnt, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
